bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial feeder that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock. Its `bit_out` drives the `in_bit` input of the `mealy_fsm` "01" sequence detector. A one-word holding register lets back-to-back words stream with no idle gap. When no data is queued, the serial line holds a fixed idle level.

## Interface

**Parameters**
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 = MSB shifted first; 0 = LSB first.
- `IDLE_BIT`, default 1'b1: level driven on `bit_out` when no bit is valid.

**Ports**
- `clk`  in  1: clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `din`  in  WIDTH: word to serialize.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: holding register can accept a word.
- `bit_out`  out  1: serial bit, registered.
- `bit_valid`  out  1: `bit_out` carries a data (or parity) bit.
- `word_done`  out  1: high during the cycle carrying the final bit of a word.
- `busy`  out  1: shifter active or holding register full.

## Operation

- **Reset values:** `bit_out` = `IDLE_BIT`, `bit_valid` = 0, `word_done` = 0, `busy` = 0. Holding register and shifter are empty.
- `din_ready` = `!hold_full && !reset`, so it is forced low while `reset` is asserted.
- **Accept:** a word is accepted on an edge where `din_valid && din_ready`. `din` is latched into `hold` and `hold_full` is set.
- **States:** IDLE, SHIFT, PARITY (PARITY exists only with the macro defined).
- **IDLE → SHIFT:** taken on an edge where `hold_full` = 1. That edge:
  - copies `hold` into the shifter,
  - clears `hold_full`,
  - drives the first bit on `bit_out` with `bit_valid` = 1,
  - sets the bit counter to 1.
- **SHIFT:** each edge presents the next bit (MSB→LSB if `MSB_FIRST`, else LSB→MSB) and increments the counter.
- **End of last data bit:** the edge that ends the cycle carrying bit WIDTH goes to:
  - PARITY, if enabled; else
  - SHIFT with the next word loaded, if `hold_full`; else
  - IDLE.
- **Loading from PARITY:** the same load rule applies on the edge that ends the parity cycle.
- **Back-to-back:** when the next word is loaded on the final-bit edge, its first bit follows the previous final bit in the very next cycle, with `bit_valid` staying high and no gap.
- **IDLE outputs:** `bit_out` = `IDLE_BIT`, `bit_valid` = 0.
- **Simultaneous events:** load-from-hold and accept cannot occur on the same edge, because `din_ready` is low while `hold_full` = 1. `din_ready` rises the cycle after `hold` is consumed.
- **Reset mid-word:** the in-flight word and the held word are discarded. The next cycle shows idle outputs, and no `word_done` is produced for the aborted word.

## Timing

- **Latency:** handshake accepted at edge E0 → first bit on `bit_out` in the cycle following edge E1. When the shifter is busy, the first bit appears immediately after the previous word's final bit.
- **Word period:** WIDTH cycles without parity, WIDTH+1 with parity.
- **Sustained throughput:** one word per word period when the upstream re-asserts `din_valid` within WIDTH−1 cycles of `din_ready` rising.
- `word_done` is a one-cycle pulse aligned with the final bit.
- All outputs are registered except `din_ready`, which is a combinational function of registers and `reset`.

## Configuration

- **`BIT_SERIALIZER_PARITY_EN` defined:**
  - After the WIDTH data bits, one PARITY cycle emits even parity (XOR of all data bits) with `bit_valid` = 1.
  - `word_done` moves from the last data bit to the parity cycle.
  - Word period is WIDTH+1.
- **Undefined:**
  - No PARITY state or parity logic.
  - `word_done` is on the last data bit.
  - Word period is WIDTH.

## Test plan

- **Reset:** assert `reset` 3 cycles with `din_valid` = 1 → `din_ready` = 0, `bit_out` = 1, `bit_valid` = 0 throughout. After release, `din_ready` = 1 and `busy` = 0.
- **Single word, MSB-first:** `din` = 8'hA5 → bits 1,0,1,0,0,1,0,1 with `bit_valid` = 1 in the 8 cycles starting the cycle after E1. `word_done` on the 8th bit; then `bit_out` = 1, `bit_valid` = 0.
- **Back-to-back:** 8'h0F then 8'hF0 with `din_valid` held → 16 contiguous valid bits 0000111111110000. Single `word_done` pulses on bits 8 and 16. `din_ready` is low exactly while `hold_full` = 1.
- **LSB-first:** `MSB_FIRST` = 0, `din` = 8'h01 → bit 1 followed by seven 0s.
- **Parity:** with `BIT_SERIALIZER_PARITY_EN`, `din` = 8'h07 → data 00000111 then parity bit 1 on cycle 9 with `word_done`. `din` = 8'h03 → parity 0.
- **Reset mid-word:** reset after 3 bits of 8'h00 with a second word held → next cycle idle (`bit_out` = 1, `bit_valid` = 0), no `word_done`. A new word 8'h81 afterwards serializes cleanly as 10000001.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Word-level valid/ready handshake feeding bit_serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with a one-word holding register for gapless streaming.
// Optional even-parity bit after each word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter logic        IDLE_BIT  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    bit_serializer_if.slave     up,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                word_done,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef BIT_SERIALIZER_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   hold_q, hold_n;
    logic               hold_full_q, hold_full_n;
    logic [WIDTH-1:0]   shreg_q, shreg_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               bit_out_n, bit_valid_n, word_done_n, busy_n;
    logic               load, accept;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic               par_q, par_n;
`endif

    assign up.din_ready = !hold_full_q && !reset;
    assign accept       = up.din_valid && up.din_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_out     <= IDLE_BIT;
            bit_valid   <= 1'b0;
            word_done   <= 1'b0;
            busy        <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            hold_q      <= hold_n;
            hold_full_q <= hold_full_n;
            shreg_q     <= shreg_n;
            cnt_q       <= cnt_n;
            bit_out     <= bit_out_n;
            bit_valid   <= bit_valid_n;
            word_done   <= word_done_n;
            busy        <= busy_n;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q       <= par_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state_q;
        hold_n      = hold_q;
        hold_full_n = hold_full_q;
        shreg_n     = shreg_q;
        cnt_n       = cnt_q;
        bit_out_n   = IDLE_BIT;
        bit_valid_n = 1'b0;
        word_done_n = 1'b0;
        load        = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_n       = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                load = hold_full_q;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_n     = S_PARITY;
                    bit_out_n   = par_q;
                    bit_valid_n = 1'b1;
                    word_done_n = 1'b1;
`else
                    load    = hold_full_q;
                    state_n = S_IDLE;
`endif
                end else begin
                    bit_out_n   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
                    shreg_n     = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_n       = cnt_q + CNT_W'(1);
                    bit_valid_n = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                    word_done_n = (cnt_q == CNT_W'(WIDTH - 1));
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                load    = hold_full_q;
                state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase

        // Loading overrides the idle fallback so the next word follows with no gap
        if (load) begin
            state_n     = S_SHIFT;
            bit_out_n   = (MSB_FIRST != 0) ? hold_q[WIDTH-1] : hold_q[0];
            shreg_n     = (MSB_FIRST != 0) ? (hold_q << 1) : (hold_q >> 1);
            cnt_n       = CNT_W'(1);
            bit_valid_n = 1'b1;
            word_done_n = 1'b0;
            hold_full_n = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_n       = ^hold_q;
`endif
        end

        if (accept) begin
            hold_n      = up.din;
            hold_full_n = 1'b1;
        end

        busy_n = (state_n != S_IDLE) || hold_full_n;
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first instance.
module tb_bit_serializer;
    localparam int unsigned WIDTH = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int P = WIDTH + PAR;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    bit_serializer_if #(.WIDTH(WIDTH)) m_if ();
    bit_serializer_if #(.WIDTH(WIDTH)) l_if ();

    logic m_bo, m_bv, m_wd, m_busy;
    logic l_bo, l_bv, l_wd, l_busy;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .reset(reset), .up(m_if.slave),
        .bit_out(m_bo), .bit_valid(m_bv), .word_done(m_wd), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .up(l_if.slave),
        .bit_out(l_bo), .bit_valid(l_bv), .word_done(l_wd), .busy(l_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Hand off one word; checks the hold-full cycle before the first bit
    task automatic send(input bit lsb, input logic [WIDTH-1:0] w);
        @(negedge clk);
        if (lsb) begin l_if.din = w; l_if.din_valid = 1'b1; end
        else     begin m_if.din = w; m_if.din_valid = 1'b1; end
        @(negedge clk);
        l_if.din_valid = 1'b0;
        m_if.din_valid = 1'b0;
        chk("ready_low_held", lsb ? l_if.din_ready : m_if.din_ready, 1'b0);
        chk("valid_before_first", lsb ? l_bv : m_bv, 1'b0);
        chk("busy_held", lsb ? l_busy : m_busy, 1'b1);
    endtask

    // exp_bits[WIDTH-1] is the first bit expected on the wire
    task automatic check_word(input string tag, input bit lsb,
                              input logic [WIDTH-1:0] exp_bits, input logic exp_par);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), lsb ? l_bo : m_bo, exp_bits[WIDTH-1-i]);
            chk($sformatf("%s_valid%0d", tag, i), lsb ? l_bv : m_bv, 1'b1);
            chk($sformatf("%s_done%0d", tag, i), lsb ? l_wd : m_wd,
                (i == WIDTH - 1) && (PAR == 0));
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        @(negedge clk);
        chk($sformatf("%s_parity", tag), lsb ? l_bo : m_bo, exp_par);
        chk($sformatf("%s_par_valid", tag), lsb ? l_bv : m_bv, 1'b1);
        chk($sformatf("%s_par_done", tag), lsb ? l_wd : m_wd, 1'b1);
`else
        if (exp_par === 1'bx) $display("unexpected X parity for %s", tag);
`endif
    endtask

    task automatic check_idle(input string tag, input bit lsb);
        @(negedge clk);
        chk({tag, "_idle_bit"}, lsb ? l_bo : m_bo, 1'b1);
        chk({tag, "_idle_valid"}, lsb ? l_bv : m_bv, 1'b0);
        chk({tag, "_idle_done"}, lsb ? l_wd : m_wd, 1'b0);
        chk({tag, "_idle_busy"}, lsb ? l_busy : m_busy, 1'b0);
    endtask

    logic [15:0] b2b_bits;
    logic        exp_b;

    initial begin
        // Reset held three cycles with din_valid asserted
        reset = 1'b1;
        m_if.din = 8'hFF; m_if.din_valid = 1'b1;
        l_if.din = 8'hFF; l_if.din_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", m_if.din_ready, 1'b0);
            chk("rst_bit", m_bo, 1'b1);
            chk("rst_valid", m_bv, 1'b0);
        end
        reset = 1'b0;
        m_if.din_valid = 1'b0;
        l_if.din_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", m_if.din_ready, 1'b1);
        chk("post_rst_busy", m_busy, 1'b0);
        chk("post_rst_wd", m_wd, 1'b0);

        // Single word MSB-first; parity of A5 is 0
        send(1'b0, 8'hA5);
        check_word("a5", 1'b0, 8'b10100101, 1'b0);
        check_idle("a5", 1'b0);

        // Back-to-back 0F, F0 with din_valid held until the second accept
        b2b_bits = 16'b0000111111110000;
        @(negedge clk);
        m_if.din = 8'h0F; m_if.din_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_hold1", m_if.din_ready, 1'b0);
        chk("b2b_valid_pre", m_bv, 1'b0);
        m_if.din = 8'hF0;
        for (int c = 0; c < 2 * P; c++) begin
            @(negedge clk);
            if ((c % P) == WIDTH) exp_b = 1'b0;
            else                  exp_b = b2b_bits[15 - ((c / P) * WIDTH + (c % P))];
            chk($sformatf("b2b_bit%0d", c), m_bo, exp_b);
            chk($sformatf("b2b_valid%0d", c), m_bv, 1'b1);
            chk($sformatf("b2b_done%0d", c), m_wd, (c == P - 1) || (c == 2 * P - 1));
            chk($sformatf("b2b_ready%0d", c), m_if.din_ready, (c == 0) || (c >= P));
            if (c == 1) m_if.din_valid = 1'b0;
        end
        check_idle("b2b", 1'b0);

        // LSB-first 01: 1 then seven 0s, parity 1
        send(1'b1, 8'h01);
        check_word("lsb01", 1'b1, 8'b10000000, 1'b1);
        check_idle("lsb01", 1'b1);

        // Parity vectors (plain words when parity is disabled)
        send(1'b0, 8'h07);
        check_word("p07", 1'b0, 8'b00000111, 1'b1);
        check_idle("p07", 1'b0);
        send(1'b0, 8'h03);
        check_word("p03", 1'b0, 8'b00000011, 1'b0);
        check_idle("p03", 1'b0);

        // Reset after three bits of 00 with 55 held
        @(negedge clk);
        m_if.din = 8'h00; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din = 8'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mid_bit%0d", c), m_bo, 1'b0);
            chk($sformatf("mid_valid%0d", c), m_bv, 1'b1);
            if (c == 1) begin
                chk("mid_ready_held", m_if.din_ready, 1'b0);
                m_if.din_valid = 1'b0;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_bit", m_bo, 1'b1);
        chk("mid_rst_valid", m_bv, 1'b0);
        chk("mid_rst_done", m_wd, 1'b0);
        chk("mid_rst_busy", m_busy, 1'b0);
        chk("mid_rst_ready", m_if.din_ready, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("mid_quiet_valid%0d", c), m_bv, 1'b0);
            chk($sformatf("mid_quiet_done%0d", c), m_wd, 1'b0);
        end
        send(1'b0, 8'h81);
        check_word("r81", 1'b0, 8'b10000001, 1'b0);
        check_idle("r81", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
